// File: rtl/f_addsub_front.sv
// f_addsub_front: FP add/sub front end, four elastic stages (capture, align prep, shift, add).
// Define FADD_SHIFT_STICKY_EN to fold bits shifted past the bottom of rest into rest[0].
`ifndef SPEF_CNT
`define SPEF_CNT 2
`endif
`ifndef SPEF_NAN
`define SPEF_NAN 0
`endif
`ifndef SPEF_INF
`define SPEF_INF 1
`endif

module f_addsub_front #(
  parameter int INFO_W = 1,
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic                  a_sign,
  input  logic                  b_sign,
  input  logic [EXP_W:0]        a_exp,
  input  logic [EXP_W:0]        b_exp,
  input  logic [FRAC_W:0]       a_frac,
  input  logic [FRAC_W:0]       b_frac,
  input  logic [`SPEF_CNT-1:0]  a_spef,
  input  logic [`SPEF_CNT-1:0]  b_spef,
  input  logic [INFO_W-1:0]     info_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+1:0]      res_exp,
  output logic [2*FRAC_W+3:0]   res_frac,
  output logic                  invalid,
  output logic                  res_inf,
  output logic                  res_inf_sign,
  output logic [INFO_W-1:0]     info_out
);
  localparam int EW = EXP_W + 1;
  localparam int RW = FRAC_W + 1;
  localparam int FW = FRAC_W + 3;
  localparam int OW = FW + RW;
  localparam int SW = $clog2(FRAC_W + 4);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [INFO_W-1:0] TAG = INFO_W'(1);

  typedef struct packed {
    logic              a_sign;
    logic              eb_sign;
    logic              a_nan;
    logic              a_inf;
    logic              b_nan;
    logic              b_inf;
    logic [EW-1:0]     a_exp;
    logic [EW-1:0]     b_exp;
    logic [RW-1:0]     a_frac;
    logic [RW-1:0]     b_frac;
    logic [INFO_W-1:0] info;
  } s1_t;

  typedef struct packed {
    logic [EW-1:0]     max_exp;
    logic [FW-1:0]     fa;
    logic [FW-1:0]     fb;
    logic [SW-1:0]     d;
    logic              inv;
    logic              inf;
    logic              inf_sign;
    logic [INFO_W-1:0] info;
  } s2_t;

  typedef struct packed {
    logic [EW-1:0]     max_exp;
    logic [FW-1:0]     fa;
    logic [FW-1:0]     fb_al;
    logic [RW-1:0]     rest;
    logic              inv;
    logic              inf;
    logic              inf_sign;
    logic [INFO_W-1:0] info;
  } s3_t;

  typedef struct packed {
    logic [EW:0]       exp;
    logic [OW-1:0]     frac;
    logic              inv;
    logic              inf;
    logic              inf_sign;
    logic [INFO_W-1:0] info;
  } s4_t;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic adv1, adv2, adv3, adv4;
  logic ld1, ld2, ld3, ld4;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  s4_t s4_q, s4_d;

  // Each stage moves on when its successor is empty or itself moving; flush overrides everything.
  always_comb begin
    adv4 = v4_q & out_ready;
    adv3 = v3_q & (~v4_q | adv4);
    adv2 = v2_q & (~v3_q | adv3);
    adv1 = v1_q & (~v2_q | adv2);
    in_ready = ~v1_q | adv1;
    ld1 = in_valid & in_ready & ~flush;
    ld2 = adv1 & ~flush;
    ld3 = adv2 & ~flush;
    ld4 = adv3 & ~flush;
    v1_d = ~flush & (ld1 | (v1_q & ~adv1));
    v2_d = ~flush & (ld2 | (v2_q & ~adv2));
    v3_d = ~flush & (ld3 | (v3_q & ~adv3));
    v4_d = ~flush & (ld4 | (v4_q & ~adv4));
  end

  always_comb begin
    s1_d = s1_q;
    if (ld1) begin
      s1_d.a_sign  = a_sign;
      s1_d.eb_sign = b_sign ^ op_sub;
      s1_d.a_nan   = a_spef[`SPEF_NAN];
      s1_d.a_inf   = a_spef[`SPEF_INF];
      s1_d.b_nan   = b_spef[`SPEF_NAN];
      s1_d.b_inf   = b_spef[`SPEF_INF];
      s1_d.a_exp   = a_exp;
      s1_d.b_exp   = b_exp;
      s1_d.a_frac  = a_frac;
      s1_d.b_frac  = b_frac;
      s1_d.info    = info_in;
    end
    if (flush) s1_d.info = s1_d.info & ~TAG;
  end

  logic          a_ge, inv2;
  logic [EW:0]   ea_x, eb_x, diff;
  logic [FW-1:0] fa_s, fb_s;

  // Ties keep the original a as the larger operand.
  always_comb begin
    ea_x = {s1_q.a_exp[EW-1], s1_q.a_exp};
    eb_x = {s1_q.b_exp[EW-1], s1_q.b_exp};
    a_ge = $signed(ea_x) >= $signed(eb_x);
    diff = a_ge ? ea_x - eb_x : eb_x - ea_x;
    fa_s = s1_q.a_sign ? -{2'b0, s1_q.a_frac} : {2'b0, s1_q.a_frac};
    fb_s = s1_q.eb_sign ? -{2'b0, s1_q.b_frac} : {2'b0, s1_q.b_frac};
    inv2 = s1_q.a_nan | s1_q.b_nan | (s1_q.a_inf & s1_q.b_inf & (s1_q.a_sign ^ s1_q.eb_sign));
    s2_d = s2_q;
    if (ld2) begin
      s2_d.max_exp  = a_ge ? s1_q.a_exp : s1_q.b_exp;
      s2_d.fa       = a_ge ? fa_s : fb_s;
      s2_d.fb       = a_ge ? fb_s : fa_s;
      s2_d.d        = diff > (EW + 1)'(FW) ? SW'(FW) : diff[SW-1:0];
      s2_d.inv      = inv2;
      s2_d.inf      = ~inv2 & (s1_q.a_inf | s1_q.b_inf);
      s2_d.inf_sign = s1_q.a_inf ? s1_q.a_sign : s1_q.eb_sign;
      s2_d.info     = s1_q.info;
    end
    if (flush) s2_d.info = s2_d.info & ~TAG;
  end

  logic signed [OW-1:0] sh;
  logic                 lost;
`ifdef FADD_SHIFT_STICKY_EN
  // A further FW guard bits catch everything the saturated shift can push out.
  logic signed [OW+FW-1:0] ext;
  assign ext  = $signed({s2_q.fb, {OW{1'b0}}}) >>> s2_q.d;
  assign sh   = ext[OW+FW-1 -: OW];
  assign lost = |ext[FW-1:0];
`else
  assign sh   = $signed({s2_q.fb, {RW{1'b0}}}) >>> s2_q.d;
  assign lost = 1'b0;
`endif

  always_comb begin
    s3_d = s3_q;
    if (ld3) begin
      s3_d.max_exp  = s2_q.max_exp;
      s3_d.fa       = s2_q.fa;
      s3_d.fb_al    = sh[OW-1 -: FW];
      s3_d.rest     = {sh[RW-1:1], sh[0] | lost};
      s3_d.inv      = s2_q.inv;
      s3_d.inf      = s2_q.inf;
      s3_d.inf_sign = s2_q.inf_sign;
      s3_d.info     = s2_q.info;
    end
    if (flush) s3_d.info = s3_d.info & ~TAG;
  end

  always_comb begin
    s4_d = s4_q;
    if (ld4) begin
      s4_d.exp      = {1'b0, s3_q.max_exp + BIAS};
      s4_d.frac     = {s3_q.fa + s3_q.fb_al, s3_q.rest};
      s4_d.inv      = s3_q.inv;
      s4_d.inf      = s3_q.inf;
      s4_d.inf_sign = s3_q.inf_sign;
      s4_d.info     = s3_q.info;
    end
    if (flush) s4_d.info = s4_d.info & ~TAG;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end

  assign out_valid    = v4_q;
  assign res_exp      = s4_q.exp;
  assign res_frac     = s4_q.frac;
  assign invalid      = s4_q.inv;
  assign res_inf      = s4_q.inf;
  assign res_inf_sign = s4_q.inf_sign;
  assign info_out     = s4_q.info;
endmodule

// File: tb/tb_f_addsub_front.sv
// tb_f_addsub_front: vector table plus flow-control sequences, checked through an in-order scoreboard.
`ifndef SPEF_CNT
`define SPEF_CNT 2
`endif
`ifndef SPEF_NAN
`define SPEF_NAN 0
`endif
`ifndef SPEF_INF
`define SPEF_INF 1
`endif

module tb_f_addsub_front;
  localparam int IW = 8;
  localparam logic [52:0] ONE   = 53'h10_0000_0000_0000;
  localparam logic [52:0] THREE = 53'h18_0000_0000_0000;
  localparam logic [`SPEF_CNT-1:0] Z    = '0;
  localparam logic [`SPEF_CNT-1:0] NANF = `SPEF_CNT'(1 << `SPEF_NAN);
  localparam logic [`SPEF_CNT-1:0] INFF = `SPEF_CNT'(1 << `SPEF_INF);
  localparam logic [107:0] P106 = 108'd1 << 106;
  localparam logic [107:0] P105 = 108'd1 << 105;
  localparam logic [107:0] P104 = 108'd1 << 104;
  localparam logic [107:0] P102 = 108'd1 << 102;
  localparam logic [107:0] P50  = 108'd1 << 50;
  localparam logic [54:0]  M1   = 55'h78_0000_0000_0000;
  localparam logic [54:0]  M2   = 55'h60_0000_0000_0000;
`ifdef FADD_SHIFT_STICKY_EN
  localparam logic [107:0] STK = 108'd1;
`else
  localparam logic [107:0] STK = 108'd0;
`endif

  logic clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic op_sub = 0, a_sign = 0, b_sign = 0;
  logic [11:0] a_exp = '0, b_exp = '0;
  logic [52:0] a_frac = '0, b_frac = '0;
  logic [`SPEF_CNT-1:0] a_spef = '0, b_spef = '0;
  logic [IW-1:0] info_in = '0;
  logic in_ready, out_valid, invalid, res_inf, res_inf_sign;
  logic [12:0] res_exp;
  logic [107:0] res_frac;
  logic [IW-1:0] info_out;

  f_addsub_front #(.INFO_W(IW), .EXP_W(11), .FRAC_W(52)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_frac(a_frac), .b_frac(b_frac), .a_spef(a_spef), .b_spef(b_spef), .info_in(info_in),
    .out_valid(out_valid), .out_ready(out_ready), .res_exp(res_exp), .res_frac(res_frac),
    .invalid(invalid), .res_inf(res_inf), .res_inf_sign(res_inf_sign), .info_out(info_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic op, as, bs;
    logic [11:0] ae, be;
    logic [52:0] af, bf;
    logic [`SPEF_CNT-1:0] asp, bsp;
    logic [12:0] x_exp;
    logic [107:0] x_frac;
    logic x_inv, x_inf, x_isg, num;
  } vec_t;

  typedef struct {
    logic [12:0] x_exp;
    logic [107:0] x_frac;
    logic x_inv, x_inf, x_isg, num;
    logic [IW-1:0] info;
  } exp_t;

  vec_t tv[$];
  exp_t q[$];
  exp_t e;
  int nvec = 0, nerr = 0;
  logic [6:0] tag = '0;

  function automatic vec_t mk(input logic op, input logic as, input logic [11:0] ae, input logic [52:0] af,
                              input logic [`SPEF_CNT-1:0] asp, input logic bs, input logic [11:0] be,
                              input logic [52:0] bf, input logic [`SPEF_CNT-1:0] bsp, input logic [12:0] xe,
                              input logic [107:0] xf, input logic xi, input logic xn, input logic xs,
                              input logic nm);
    vec_t v;
    v.op = op; v.as = as; v.ae = ae; v.af = af; v.asp = asp;
    v.bs = bs; v.be = be; v.bf = bf; v.bsp = bsp;
    v.x_exp = xe; v.x_frac = xf; v.x_inv = xi; v.x_inf = xn; v.x_isg = xs; v.num = nm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic send(input vec_t v, input bit track);
    int n;
    exp_t x;
    @(negedge clk);
    op_sub = v.op; a_sign = v.as; b_sign = v.bs; a_exp = v.ae; b_exp = v.be;
    a_frac = v.af; b_frac = v.bf; a_spef = v.asp; b_spef = v.bsp;
    info_in = {tag, 1'b1};
    in_valid = 1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send timeout: op %0d not accepted", tag);
    end else if (track) begin
      x.x_exp = v.x_exp; x.x_frac = v.x_frac; x.x_inv = v.x_inv;
      x.x_inf = v.x_inf; x.x_isg = v.x_isg; x.num = v.num; x.info = info_in;
      q.push_back(x);
    end
    tag++;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d results never appeared", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (resetn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected output: info %0h, expected no output", info_out);
      end else begin
        e = q.pop_front();
        chk($sformatf("info#%0d", e.info[7:1]), 128'(info_out), 128'(e.info));
        if (e.num) begin
          chk($sformatf("res_exp#%0d", e.info[7:1]), 128'(res_exp), 128'(e.x_exp));
          chk($sformatf("res_frac#%0d", e.info[7:1]), 128'(res_frac), 128'(e.x_frac));
        end
        chk($sformatf("invalid#%0d", e.info[7:1]), 128'(invalid), 128'(e.x_inv));
        chk($sformatf("res_inf#%0d", e.info[7:1]), 128'(res_inf), 128'(e.x_inf));
        if (e.x_inf) chk($sformatf("inf_sign#%0d", e.info[7:1]), 128'(res_inf_sign), 128'(e.x_isg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // op as ae af asp | bs be bf bsp | exp frac inv inf isg num
    tv.push_back(mk(0, 0, 12'd0, ONE, Z, 0, 12'd0, ONE, Z, 13'd1023, P106, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 12'd0, ONE, Z, 0, 12'd0, ONE, Z, 13'd1023, 108'd0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 12'd1, ONE, Z, 0, 12'd0, ONE, Z, 13'd1024, P104, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 12'd0, ONE, Z, 0, 12'd1, ONE, Z, 13'd1024, {M1, 53'd0}, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'd0, ONE, Z, 0, 12'd1, ONE, Z, 13'd1024, P104 * 3, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'd0, ONE, Z, 1, 12'd0, ONE, Z, 13'd1023, {M2, 53'd0}, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'd0, ONE, Z, 0, 12'(-60), ONE, Z, 13'd1023, P105 | P50, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'd0, ONE, Z, 0, 12'(-60), ONE | 53'd1, Z, 13'd1023, P105 | P50 | STK, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 12'd0, ONE, Z, 0, 12'(-60), ONE, Z, 13'd1023, P105 - P50, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'd3, ONE, Z, 0, 12'd0, ONE, Z, 13'd1026, P105 | P102, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'(-1023), ONE, Z, 0, 12'(-1023), ONE, Z, 13'd0, P106, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'h800, ONE, Z, 0, 12'h7FF, ONE, Z, 13'd3070, P105 | P50, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'h7FF, ONE, Z, 0, 12'h7FF, ONE, Z, 13'd3070, P106, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 12'd0, ONE, INFF, 0, 12'd0, ONE, INFF, 13'd0, 108'd0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 12'd0, ONE, INFF, 0, 12'd1, THREE, Z, 13'd0, 108'd0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 12'd0, ONE, NANF, 0, 12'd0, ONE, Z, 13'd0, 108'd0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 12'd0, ONE, Z, 1, 12'd0, ONE, NANF, 13'd0, 108'd0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 12'd0, ONE, INFF, 0, 12'd0, ONE, Z, 13'd0, 108'd0, 0, 1, 1, 0));
    tv.push_back(mk(1, 0, 12'd0, ONE, Z, 0, 12'd0, ONE, INFF, 13'd0, 108'd0, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 12'd0, ONE, INFF, 0, 12'd0, ONE, INFF, 13'd0, 108'd0, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 12'd0, ONE, INFF, 1, 12'd0, ONE, INFF, 13'd0, 108'd0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 12'd0, ONE, NANF, 0, 12'd0, ONE, INFF, 13'd0, 108'd0, 1, 0, 0, 0));

    repeat (2) @(negedge clk);
    #2;
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset res_frac", 128'(res_frac), 128'd0);
    chk("reset res_exp", 128'(res_exp), 128'd0);
    chk("reset info_out", 128'(info_out), 128'd0);
    chk("reset flags", 128'({invalid, res_inf, res_inf_sign}), 128'd0);
    resetn = 1;
    @(negedge clk);
    #2;
    chk("in_ready after reset", 128'(in_ready), 128'd1);

    for (int i = 0; i < tv.size(); i++) send(tv[i], 1);
    idle();
    drain();

    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(tv[i], 1);
    idle();
    #2;
    chk("in_ready full", 128'(in_ready), 128'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("stall out_valid", 128'(out_valid), 128'd1);
    chk("stall in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    out_ready = 1;
    send(tv[4], 1);
    send(tv[5], 1);
    idle();
    drain();

    for (int i = 0; i < 3; i++) send(tv[i], 0);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    #2;
    chk("out_valid after flush", 128'(out_valid), 128'd0);
    chk("info tag after flush", 128'(info_out[0]), 128'd0);
    repeat (10) @(negedge clk);
    #2;
    chk("out_valid flush settle", 128'(out_valid), 128'd0);

    for (int i = 0; i < 3; i++) send(tv[i], 0);
    @(negedge clk);
    resetn = 0;
    in_valid = 0;
    @(negedge clk);
    #2;
    chk("midreset out_valid", 128'(out_valid), 128'd0);
    chk("midreset res_frac", 128'(res_frac), 128'd0);
    chk("midreset res_exp", 128'(res_exp), 128'd0);
    chk("midreset info_out", 128'(info_out), 128'd0);
    chk("midreset flags", 128'({invalid, res_inf, res_inf_sign}), 128'd0);
    resetn = 1;
    @(negedge clk);
    #2;
    chk("midreset in_ready", 128'(in_ready), 128'd1);
    repeat (10) @(negedge clk);
    #2;
    chk("midreset settle", 128'(out_valid), 128'd0);

    send(tv[0], 1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
